ahb_bus_matrix_arbiter_gen: RTL and testbench
=============================================

AHB_BUS_MATRIX_ARBITER_GEN -- requirements
Module: ahb_bus_matrix_arbiter_gen

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of input ports requesting the shared slave; legal range 2..16.
REQ-002 Parameter PORT_W, default 2: width of addr_in_port; SHALL equal ceil(log2(NUM_PORTS)), minimum 1.
REQ-003 Parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 Parameter INCR_HOLD_BEATS, default 4: minimum beats an undefined-length INCR burst holds the grant; legal range 2..16.
REQ-005 Parameter EARLY_INCR_MAX, default 1: count of consecutive early-terminated INCR bursts after which INCR no longer holds; legal range 1..3.
REQ-006 HCLK  input  1  AHB system clock; all state on rising edge.
REQ-007 HRESET  input  1  reset; synchronous, active-high.
REQ-008 req_port  input  NUM_PORTS  bit i = input port i requests this output.
REQ-009 HREADYM  input  1  transfer done; all state updates only when high.
REQ-010 HSELM  input  1  slave select of the current output transfer.
REQ-011 HTRANSM  input  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-012 HBURSTM  input  3  burst type (000 SINGLE, 001 INCR, 010/011 4-beat, 100/101 8-beat, 110/111 16-beat).
REQ-013 HMASTLOCKM  input  1  locked transfer.
REQ-014 addr_in_port  output  PORT_W  index of the granted input port, registered.
REQ-015 no_port  output  1  high when no input port is granted, registered.
REQ-016 burst_hold  output  1  registered burst-hold flag; high while a burst pins the grant.

Function
REQ-017 Burst next-state, computed combinationally: HSELM low or IDLE -> remain=0, hold=0; BUSY -> remain and hold unchanged.
REQ-018 NONSEQ sets (remain, hold): 16-beat (14,1); 8-beat (6,1); 4-beat (2,1); SINGLE (0,0).
REQ-019 NONSEQ INCR sets (INCR_HOLD_BEATS-2, 1), except (0,0) when early_count equals EARLY_INCR_MAX.
REQ-020 SEQ: remain==0 -> (0,0); otherwise remain-1 with hold unchanged; remain is 4 bits and never wraps below 0.
REQ-021 early_count next: 0 if next hold is 0; early_count+1 if registered hold is 1 and HTRANSM is NONSEQ; otherwise unchanged. early_count saturates at 3.
REQ-022 Grant freeze: if HMASTLOCKM or next hold is high, next grant = current addr_in_port and next no_port = 0.
REQ-023 From no_port=1: next grant = lowest-index requesting port. If req_port==0, no_port stays 1 and addr_in_port is unchanged.
REQ-024 Round-robin with port c granted: search c+1, c+2, ... wrapping modulo NUM_PORTS, excluding c; the first requester wins.
REQ-025 Round-robin with no other requester: keep c if HSELM is high; otherwise set no_port=1 and leave addr_in_port unchanged.
REQ-026 Fixed priority with port c granted: the lowest-index requester wins, including c. If there is no requester, keep c if HSELM is high; otherwise set no_port=1.
REQ-027 addr_in_port, no_port, remain, hold and early_count SHALL load only on HCLK rising edges with HREADYM high; HREADYM low holds every register.
REQ-028 addr_in_port SHALL never take a value >= NUM_PORTS; no X is produced for any legal input encoding.
REQ-029 Arbitration decision latency: one HCLK edge with HREADYM high, from inputs to registered outputs.

Reset
REQ-030 HRESET high at a rising HCLK edge: addr_in_port=0, no_port=1, burst_hold=0, remain=0, early_count=0, regardless of HREADYM.
REQ-031 Reset mid-burst or mid-lock SHALL abandon the hold immediately; the first post-reset decision follows REQ-023.

Verification (NUM_PORTS=4, defaults unless stated)
REQ-032 Reset, then req_port=0100 with HREADYM=1 -> after 1 edge addr_in_port=2, no_port=0.
REQ-033 Port 1 granted, NONSEQ INCR8 with HSELM=1, req_port=1111 -> grant stays 1 through 7 SEQ beats, then moves to 2 at the next arbitration.
REQ-034 Port 3 granted, round-robin, req_port=0011, no burst -> next grant 0 (wrap-around); with ARB_MODE=1 and req_port=1010 -> next grant 1.
REQ-035 Back-to-back 3-beat INCR bursts from port 0 with req_port=0011 -> the second INCR NONSEQ does not hold (early_count=1), and the grant moves to 1.
REQ-036 HMASTLOCKM=1 with HTRANSM=IDLE and req_port=1110 on port 0 -> grant stays 0; HREADYM=0 for 5 cycles freezes all outputs.
REQ-037 Port 2 granted, HSELM=0, req_port=0000 -> no_port=1 and addr_in_port stays 2; HRESET asserted mid-INCR16 -> outputs match REQ-030 on the next edge.

Source files
------------

// File: rtl/ahb_bus_matrix_arbiter_gen.sv
// AHB bus-matrix output-stage arbiter: picks which input port owns the shared slave.
// Latency: one HCLK edge with HREADYM high. Backpressure: HREADYM low stalls every register.
module ahb_bus_matrix_arbiter_gen #(
  parameter int NUM_PORTS       = 4,
  parameter int PORT_W          = 2,
  parameter int ARB_MODE        = 0,
  parameter int INCR_HOLD_BEATS = 4,
  parameter int EARLY_INCR_MAX  = 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic                 burst_hold
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  localparam logic [3:0] INCR_REMAIN = 4'(INCR_HOLD_BEATS - 2);
  localparam logic [1:0] EARLY_MAX   = 2'(EARLY_INCR_MAX);

  logic [PORT_W-1:0] grant_q, grant_d;
  logic              no_port_q, no_port_d;
  logic [3:0]        remain_q, remain_d;
  logic              hold_q, hold_d;
  logic [1:0]        early_q, early_d;
  logic [1:0]        early_cand;

  logic              lo_found;
  logic [PORT_W-1:0] lo_idx;
  logic              rr_found;
  logic [PORT_W-1:0] rr_idx;
  int                rr_pos;

  // A NONSEQ arriving while the previous INCR still holds is an early termination;
  // the INCR being started is judged against the count including that termination.
  always_comb begin
    early_cand = early_q;
    if (hold_q && HTRANSM == TR_NONSEQ) begin
      early_cand = (early_q == 2'd3) ? 2'd3 : early_q + 2'd1;
    end

    remain_d = remain_q;
    hold_d   = hold_q;
    if (!HSELM || HTRANSM == TR_IDLE) begin
      remain_d = 4'd0;
      hold_d   = 1'b0;
    end else begin
      case (HTRANSM)
        TR_BUSY: begin
        end
        TR_NONSEQ: begin
          casez (HBURSTM)
            3'b11?: begin remain_d = 4'd14; hold_d = 1'b1; end
            3'b10?: begin remain_d = 4'd6;  hold_d = 1'b1; end
            3'b01?: begin remain_d = 4'd2;  hold_d = 1'b1; end
            3'b001: begin
              if (early_cand == EARLY_MAX) begin
                remain_d = 4'd0;
                hold_d   = 1'b0;
              end else begin
                remain_d = INCR_REMAIN;
                hold_d   = 1'b1;
              end
            end
            default: begin remain_d = 4'd0; hold_d = 1'b0; end
          endcase
        end
        default: begin
          if (remain_q == 4'd0) begin
            remain_d = 4'd0;
            hold_d   = 1'b0;
          end else begin
            remain_d = remain_q - 4'd1;
          end
        end
      endcase
    end

    early_d = hold_d ? early_cand : 2'd0;
  end

  always_comb begin
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_port[i]) begin
        lo_found = 1'b1;
        lo_idx   = PORT_W'(i);
      end
    end

    // Rotating search starting just after the current owner, owner excluded.
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_pos   = 0;
    for (int k = 1; k < NUM_PORTS; k++) begin
      rr_pos = (int'(grant_q) + k) % NUM_PORTS;
      if (!rr_found && req_port[rr_pos[PORT_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_pos[PORT_W-1:0];
      end
    end
  end

  always_comb begin
    grant_d   = grant_q;
    no_port_d = no_port_q;
    if (HMASTLOCKM || hold_d) begin
      no_port_d = 1'b0;
    end else if (no_port_q) begin
      if (lo_found) begin
        grant_d   = lo_idx;
        no_port_d = 1'b0;
      end
    end else if (ARB_MODE == 0) begin
      if (rr_found) begin
        grant_d = rr_idx;
      end else if (!HSELM) begin
        no_port_d = 1'b1;
      end
    end else begin
      if (lo_found) begin
        grant_d = lo_idx;
      end else if (!HSELM) begin
        no_port_d = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_q   <= '0;
      no_port_q <= 1'b1;
      remain_q  <= 4'd0;
      hold_q    <= 1'b0;
      early_q   <= 2'd0;
    end else if (HREADYM) begin
      grant_q   <= grant_d;
      no_port_q <= no_port_d;
      remain_q  <= remain_d;
      hold_q    <= hold_d;
      early_q   <= early_d;
    end
  end

  assign addr_in_port = grant_q;
  assign no_port      = no_port_q;
  assign burst_hold   = hold_q;

endmodule

// File: tb/tb_ahb_bus_matrix_arbiter_gen.sv
// Directed bench: each step pushes hand-derived expected outputs, pops and compares after the edge.
module tb_ahb_bus_matrix_arbiter_gen;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

  logic       clk = 1'b0;
  logic       rst, rdy, sel, lock;
  logic [1:0] trans;
  logic [2:0] burst;
  logic [3:0] req;

  logic [1:0] rr_grant, fp_grant;
  logic       rr_nop, fp_nop, rr_hold, fp_hold;

  always #5 clk = ~clk;

  ahb_bus_matrix_arbiter_gen #(.NUM_PORTS(4), .PORT_W(2), .ARB_MODE(0)) u_rr (
    .HCLK(clk), .HRESET(rst), .req_port(req), .HREADYM(rdy), .HSELM(sel),
    .HTRANSM(trans), .HBURSTM(burst), .HMASTLOCKM(lock),
    .addr_in_port(rr_grant), .no_port(rr_nop), .burst_hold(rr_hold)
  );

  ahb_bus_matrix_arbiter_gen #(.NUM_PORTS(4), .PORT_W(2), .ARB_MODE(1)) u_fp (
    .HCLK(clk), .HRESET(rst), .req_port(req), .HREADYM(rdy), .HSELM(sel),
    .HTRANSM(trans), .HBURSTM(burst), .HMASTLOCKM(lock),
    .addr_in_port(fp_grant), .no_port(fp_nop), .burst_hold(fp_hold)
  );

  typedef struct {
    int g;
    int nop;
    int h;
    bit fp;
    int fg;
    int fnop;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t e_rr(input int g, input int nop, input int h);
    exp_t e;
    e.g = g; e.nop = nop; e.h = h; e.fp = 1'b0; e.fg = 0; e.fnop = 0;
    return e;
  endfunction

  function automatic exp_t e_both(input int g, input int nop, input int h, input int fg, input int fnop);
    exp_t e;
    e.g = g; e.nop = nop; e.h = h; e.fp = 1'b1; e.fg = fg; e.fnop = fnop;
    return e;
  endfunction

  task automatic drive(input logic r, input logic y, input logic s, input logic l,
                       input logic [1:0] t, input logic [2:0] b, input logic [3:0] q);
    rst = r; rdy = y; sel = s; lock = l; trans = t; burst = b; req = q;
  endtask

  task automatic step(input string tag, input exp_t e);
    exp_t got;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_val({tag, ".grant"}, 32'(rr_grant), got.g);
    check_val({tag, ".no_port"}, 32'(rr_nop), got.nop);
    check_val({tag, ".hold"}, 32'(rr_hold), got.h);
    if (got.fp) begin
      check_val({tag, ".fp_grant"}, 32'(fp_grant), got.fg);
      check_val({tag, ".fp_no_port"}, 32'(fp_nop), got.fnop);
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, IDLE, 3'b000, 4'b0000);
    step("reset0", e_both(0, 1, 0, 0, 1));
    step("reset1", e_both(0, 1, 0, 0, 1));

    drive(0, 1, 0, 0, IDLE, 3'b000, 4'b0100);
    step("first_grant", e_both(2, 0, 0, 2, 0));

    drive(0, 1, 0, 0, IDLE, 3'b000, 4'b0000);
    step("desel_release", e_both(2, 1, 0, 2, 1));
    step("no_req_idle", e_both(2, 1, 0, 2, 1));

    drive(0, 1, 0, 0, IDLE, 3'b000, 4'b0010);
    step("grant_p1", e_both(1, 0, 0, 1, 0));

    drive(0, 1, 1, 0, NONSEQ, 3'b100, 4'b1111);
    step("incr8_nonseq", e_rr(1, 0, 1));
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 1, 0, SEQ, 3'b100, 4'b1111);
      step("incr8_seq", e_rr(1, 0, 1));
    end
    step("incr8_last", e_rr(2, 0, 0));

    drive(0, 1, 1, 0, IDLE, 3'b000, 4'b1111);
    step("rr_next", e_rr(3, 0, 0));
    drive(0, 1, 1, 0, IDLE, 3'b000, 4'b0011);
    step("rr_wrap", e_rr(0, 0, 0));

    drive(0, 1, 1, 0, NONSEQ, 3'b001, 4'b0011);
    step("incr_first", e_rr(0, 0, 1));
    drive(0, 1, 1, 0, SEQ, 3'b001, 4'b0011);
    step("incr_seq1", e_rr(0, 0, 1));
    step("incr_seq2", e_rr(0, 0, 1));
    drive(0, 1, 1, 0, NONSEQ, 3'b001, 4'b0011);
    step("incr_early", e_rr(1, 0, 0));

    drive(0, 1, 1, 0, IDLE, 3'b000, 4'b0001);
    step("rr_to_p0", e_rr(0, 0, 0));
    drive(0, 1, 1, 1, IDLE, 3'b000, 4'b1110);
    step("lock0", e_rr(0, 0, 0));
    step("lock1", e_rr(0, 0, 0));

    drive(0, 0, 1, 0, IDLE, 3'b000, 4'b1110);
    for (int i = 0; i < 5; i++) step("stall", e_rr(0, 0, 0));
    drive(0, 1, 1, 0, IDLE, 3'b000, 4'b1110);
    step("after_stall", e_rr(1, 0, 0));

    drive(0, 1, 1, 0, NONSEQ, 3'b110, 4'b1111);
    step("incr16", e_rr(1, 0, 1));
    drive(0, 1, 1, 0, SEQ, 3'b110, 4'b1111);
    step("incr16_seq", e_rr(1, 0, 1));
    drive(1, 1, 1, 0, SEQ, 3'b110, 4'b1111);
    step("mid_reset", e_rr(0, 1, 0));
    drive(0, 1, 1, 0, SEQ, 3'b110, 4'b0100);
    step("post_reset", e_rr(2, 0, 0));

    drive(0, 1, 1, 0, NONSEQ, 3'b010, 4'b1111);
    step("incr4", e_rr(2, 0, 1));
    drive(0, 1, 1, 0, BUSY, 3'b010, 4'b1111);
    step("incr4_busy", e_rr(2, 0, 1));
    drive(0, 1, 1, 0, SEQ, 3'b010, 4'b1111);
    step("incr4_seq1", e_rr(2, 0, 1));
    step("incr4_seq2", e_rr(2, 0, 1));
    step("incr4_seq3", e_rr(3, 0, 0));

    drive(1, 1, 0, 0, IDLE, 3'b000, 4'b0000);
    step("mode_reset", e_both(0, 1, 0, 0, 1));
    drive(0, 1, 1, 0, IDLE, 3'b000, 4'b1000);
    step("mode_p3", e_both(3, 0, 0, 3, 0));
    drive(0, 1, 1, 0, IDLE, 3'b000, 4'b1010);
    step("mode_a", e_both(1, 0, 0, 1, 0));
    step("mode_b", e_both(3, 0, 0, 1, 0));
    drive(0, 1, 1, 0, IDLE, 3'b000, 4'b0000);
    step("mode_keep", e_both(3, 0, 0, 1, 0));
    drive(0, 1, 0, 0, IDLE, 3'b000, 4'b0000);
    step("mode_release", e_both(3, 1, 0, 1, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
